swerv_trace_collector: RTL and testbench

SWERV_TRACE_COLLECTOR -- requirements
Module: swerv_trace_collector

---
 rtl/swerv_trace_collector.sv | 182 ++++++++++++++++++
 tb/tb_swerv_trace_collector.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swerv_trace_collector.sv
// Collects up to three retired instructions per cycle into a FIFO of trace records,
// dropping whole packets on overflow and reporting the loss with a marker record.
module swerv_trace_collector #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        enable,
    input  logic        flush,
    input  logic [2:0]  trace_rv_i_valid_ip,
    input  logic [95:0] trace_rv_i_insn_ip,
    input  logic [95:0] trace_rv_i_address_ip,
    input  logic [2:0]  trace_rv_i_exception_ip,
    input  logic [4:0]  trace_rv_i_ecause_ip,
    input  logic [2:0]  trace_rv_i_interrupt_ip,
    input  logic [31:0] trace_rv_i_tval_ip,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_insn,
    output logic        out_exc,
    output logic        out_intr,
    output logic [4:0]  out_ecause,
    output logic [31:0] out_tval,
    output logic        out_marker,
    output logic        overflow
);

    localparam int unsigned SLOTS = 3;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] insn;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } rec_t;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   drop_cnt;

    logic [1:0]    n_valid;
    logic [CW-1:0] free_c;
    logic          fits_c;
    logic          wr_en_c;
    logic          drop_c;
    logic          pop_c;
    logic          marker_c;
    logic          marker_ack_c;
    logic [15:0]   drop_base_c;
    logic [16:0]   drop_sum_c;
    logic [15:0]   drop_nxt_c;
    logic [1:0]    n_wr_c;
    rec_t          slot_rec [SLOTS];
    logic [AW-1:0] slot_wa  [SLOTS];
    rec_t          head;

    // Per-slot record build and compacted write addresses (gaps skipped)
    always_comb begin
        n_valid = 2'(trace_rv_i_valid_ip[0]) + 2'(trace_rv_i_valid_ip[1])
                + 2'(trace_rv_i_valid_ip[2]);
        slot_wa[0] = wr_ptr;
        slot_wa[1] = wr_ptr + AW'(trace_rv_i_valid_ip[0]);
        slot_wa[2] = wr_ptr + AW'(trace_rv_i_valid_ip[0]) + AW'(trace_rv_i_valid_ip[1]);
        for (int k = 0; k < SLOTS; k++) begin
            slot_rec[k].addr   = trace_rv_i_address_ip[32*k +: 32];
            slot_rec[k].insn   = trace_rv_i_insn_ip[32*k +: 32];
            slot_rec[k].exc    = trace_rv_i_exception_ip[k];
            slot_rec[k].intr   = trace_rv_i_interrupt_ip[k];
            slot_rec[k].ecause = '0;
            slot_rec[k].tval   = '0;
            if (trace_rv_i_exception_ip[k] || trace_rv_i_interrupt_ip[k]) begin
                slot_rec[k].ecause = trace_rv_i_ecause_ip;
                slot_rec[k].tval   = trace_rv_i_tval_ip;
            end
        end
    end

    // Admission, drop accounting, next state and output mux
    always_comb begin
        state_nxt    = state;
        head         = mem[rd_ptr];
        free_c       = CW'(DEPTH) - count;
        fits_c       = CW'(n_valid) <= free_c;
        marker_c     = (state == RESYNC) && (count == '0);
        pop_c        = out_ready && (count != '0);
        marker_ack_c = marker_c && out_ready;
        wr_en_c      = (state == RUN) && (n_valid != 2'd0) && fits_c && !flush;
        n_wr_c       = wr_en_c ? n_valid : 2'd0;
        drop_c       = (n_valid != 2'd0) &&
                       (((state == RUN) && !fits_c) || (state == RESYNC));
        drop_base_c  = marker_ack_c ? 16'h0 : drop_cnt;
        drop_sum_c   = 17'(drop_base_c) + 17'(n_valid);
        drop_nxt_c   = drop_base_c;
        if (drop_c) begin
            drop_nxt_c = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
        end

        case (state)
            OFF: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable)     state_nxt = OFF;
                else if (drop_c) state_nxt = RESYNC;
            end
            RESYNC: begin
                if (marker_ack_c) state_nxt = enable ? RUN : OFF;
                else if (!enable) state_nxt = OFF;
            end
            default: state_nxt = OFF;
        endcase
        if (flush) state_nxt = enable ? RUN : OFF;

        out_valid  = (count != '0) || marker_c;
        overflow   = (state == RESYNC);
        out_addr   = '0;
        out_insn   = '0;
        out_exc    = 1'b0;
        out_intr   = 1'b0;
        out_ecause = '0;
        out_tval   = '0;
        out_marker = 1'b0;
        if (count != '0) begin
            out_addr   = head.addr;
            out_insn   = head.insn;
            out_exc    = head.exc;
            out_intr   = head.intr;
            out_ecause = head.ecause;
            out_tval   = head.tval;
        end else if (marker_c) begin
            out_tval   = {16'h0, drop_cnt};
            out_marker = 1'b1;
        end
    end

    // Record storage; occupancy tracking guarantees no write hits a live entry
    always_ff @(posedge clk) begin
        for (int k = 0; k < SLOTS; k++) begin
            if (wr_en_c && trace_rv_i_valid_ip[k]) begin
                mem[slot_wa[k]] <= slot_rec[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= OFF;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            state    <= state_nxt;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr + AW'(n_wr_c);
            rd_ptr   <= rd_ptr + AW'(pop_c);
            count    <= count + CW'(n_wr_c) - CW'(pop_c);
            drop_cnt <= drop_nxt_c;
        end
    end

endmodule

// File: tb/tb_swerv_trace_collector.sv
// Bench for swerv_trace_collector: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_swerv_trace_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        enable;
    logic        flush;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_insn;
    logic        out_exc;
    logic        out_intr;
    logic [4:0]  out_ecause;
    logic [31:0] out_tval;
    logic        out_marker;
    logic        overflow;

    swerv_trace_collector #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .flush(flush),
        .trace_rv_i_valid_ip(trace_rv_i_valid_ip),
        .trace_rv_i_insn_ip(trace_rv_i_insn_ip),
        .trace_rv_i_address_ip(trace_rv_i_address_ip),
        .trace_rv_i_exception_ip(trace_rv_i_exception_ip),
        .trace_rv_i_ecause_ip(trace_rv_i_ecause_ip),
        .trace_rv_i_interrupt_ip(trace_rv_i_interrupt_ip),
        .trace_rv_i_tval_ip(trace_rv_i_tval_ip),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_insn(out_insn), .out_exc(out_exc),
        .out_intr(out_intr), .out_ecause(out_ecause), .out_tval(out_tval),
        .out_marker(out_marker), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] insn;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic        marker;
    } trec_t;

    // Reference model: mode 0=off, 1=running, 2=resynchronising
    trec_t q[$];
    int    m_mode;
    int    m_drop;
    int    n_vec;
    int    n_bad;

    wire [103:0] dut_fields = {out_addr, out_insn, out_exc, out_intr, out_ecause, out_tval, out_marker};

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [103:0] pack(trec_t r);
        return {r.addr, r.insn, r.exc, r.intr, r.ecause, r.tval, r.marker};
    endfunction

    function automatic trec_t slot_rec(int k);
        trec_t r;
        r.addr   = trace_rv_i_address_ip[32*k +: 32];
        r.insn   = trace_rv_i_insn_ip[32*k +: 32];
        r.exc    = trace_rv_i_exception_ip[k];
        r.intr   = trace_rv_i_interrupt_ip[k];
        r.ecause = (r.exc | r.intr) ? trace_rv_i_ecause_ip : 5'd0;
        r.tval   = (r.exc | r.intr) ? trace_rv_i_tval_ip : 32'd0;
        r.marker = 1'b0;
        return r;
    endfunction

    function automatic trec_t exp_head();
        trec_t r = '{default: 0};
        if (q.size() > 0) r = q[0];
        else if (m_mode == 2) begin
            r.tval   = {16'h0, 16'(m_drop)};
            r.marker = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_mode = 0;
        m_drop = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        int n = $countones(trace_rv_i_valid_ip);
        int occ = q.size();
        bit marker = (m_mode == 2) && (occ == 0);
        bit dropped = 1'b0;
        if (flush) begin
            q.delete();
            m_drop = 0;
            m_mode = enable ? 1 : 0;
            return;
        end
        if (out_ready && occ > 0) void'(q.pop_front());
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: begin
                if (n > 0 && n <= DEPTH - occ) begin
                    for (int k = 0; k < 3; k++)
                        if (trace_rv_i_valid_ip[k]) q.push_back(slot_rec(k));
                end else if (n > 0) begin
                    m_drop = sat16(m_drop + n);
                    dropped = 1'b1;
                end
                if (!enable) m_mode = 0;
                else if (dropped) m_mode = 2;
            end
            default: begin
                if (marker && out_ready) begin
                    m_drop = sat16(n);
                    m_mode = enable ? 1 : 0;
                end else begin
                    m_drop = sat16(m_drop + n);
                    if (!enable) m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        trace_rv_i_valid_ip     = 3'b000;
        trace_rv_i_exception_ip = 3'b000;
        trace_rv_i_interrupt_ip = 3'b000;
        trace_rv_i_ecause_ip    = 5'd0;
        trace_rv_i_tval_ip      = 32'd0;
        flush                   = 1'b0;
    endtask

    task automatic set_slot(int k, logic [31:0] addr, logic [31:0] insn);
        trace_rv_i_address_ip[32*k +: 32] = addr;
        trace_rv_i_insn_ip[32*k +: 32]    = insn;
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", out_valid); n_bad++; end
        n_vec++;
        if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %b exp 0", overflow); n_bad++; end
        n_vec++;
        if (dut_fields !== 104'd0) begin $display("FAIL reset_fields got %h exp 0", dut_fields); n_bad++; end
    endtask

    task automatic test_basic();
        logic [31:0] ea [3];
        logic [31:0] ei [3];
        set_idle();
        enable = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            ea[k] = 32'h100 + 32'(4 * k);
            ei[k] = $urandom;
            set_slot(k, ea[k], ei[k]);
        end
        trace_rv_i_valid_ip = 3'b111;
        tick();
        set_idle();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({out_valid, out_addr, out_insn} !== {1'b1, ea[k], ei[k]}) begin
                $display("FAIL basic_rec%0d got v=%b a=%h i=%h exp v=1 a=%h i=%h", k, out_valid, out_addr, out_insn, ea[k], ei[k]);
                n_bad++;
            end
            tick();
        end
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL basic_empty got %b exp 0", out_valid); n_bad++; end
    endtask

    task automatic test_gap();
        set_slot(0, 32'h200, 32'h11);
        set_slot(1, 32'h204, 32'h22);
        set_slot(2, 32'h208, 32'h33);
        trace_rv_i_valid_ip     = 3'b101;
        trace_rv_i_exception_ip = 3'b100;
        trace_rv_i_ecause_ip    = 5'd2;
        trace_rv_i_tval_ip      = 32'hDEAD;
        tick();
        set_idle();
        n_vec++;
        if ({out_valid, out_addr, out_exc, out_ecause, out_tval} !== {1'b1, 32'h200, 1'b0, 5'd0, 32'd0}) begin
            $display("FAIL gap_first got v=%b a=%h e=%b c=%0d t=%h exp v=1 a=200 e=0 c=0 t=0", out_valid, out_addr, out_exc, out_ecause, out_tval);
            n_bad++;
        end
        tick();
        n_vec++;
        if ({out_valid, out_addr, out_exc, out_ecause, out_tval} !== {1'b1, 32'h208, 1'b1, 5'd2, 32'hDEAD}) begin
            $display("FAIL gap_second got v=%b a=%h e=%b c=%0d t=%h exp v=1 a=208 e=1 c=2 t=dead", out_valid, out_addr, out_exc, out_ecause, out_tval);
            n_bad++;
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL gap_empty got %b exp 0", out_valid); n_bad++; end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) set_slot(k, 32'h1000 + 32'(16 * p + 4 * k), 32'(p * 3 + k));
            trace_rv_i_valid_ip = 3'b111;
            tick();
        end
        n_vec++;
        if (overflow !== 1'b1) begin $display("FAIL ovf_enter got %b exp 1", overflow); n_bad++; end
        trace_rv_i_valid_ip = 3'b011;
        tick();
        set_idle();
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n_vec++;
            if ({out_valid, out_marker, out_addr} !== {1'b1, 1'b0, 32'h1000 + 32'(16 * (r / 3) + 4 * (r % 3))}) begin
                $display("FAIL ovf_drain%0d got v=%b m=%b a=%h exp v=1 m=0 a=%h", r, out_valid, out_marker, out_addr, 32'h1000 + 32'(16 * (r / 3) + 4 * (r % 3)));
                n_bad++;
            end
            tick();
        end
        n_vec++;
        if ({out_valid, out_marker, out_tval, out_addr} !== {1'b1, 1'b1, 32'h5, 32'h0}) begin
            $display("FAIL ovf_marker got v=%b m=%b t=%h a=%h exp v=1 m=1 t=5 a=0", out_valid, out_marker, out_tval, out_addr);
            n_bad++;
        end
        tick();
        n_vec++;
        if ({overflow, out_valid} !== 2'b00) begin $display("FAIL ovf_exit got ovf=%b v=%b exp 0 0", overflow, out_valid); n_bad++; end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_slot(0, 32'h3000, 32'hCAFE_F00D);
        trace_rv_i_valid_ip     = 3'b001;
        trace_rv_i_interrupt_ip = 3'b001;
        trace_rv_i_ecause_ip    = 5'd11;
        trace_rv_i_tval_ip      = 32'h1234_5678;
        tick();
        set_idle();
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if ({out_valid, dut_fields} !== {1'b1, 32'h3000, 32'hCAFE_F00D, 1'b0, 1'b1, 5'd11, 32'h1234_5678, 1'b0}) begin
                $display("FAIL stall_cycle%0d got v=%b f=%h", c, out_valid, dut_fields);
                n_bad++;
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL stall_drain got %b exp 0", out_valid); n_bad++; end
    endtask

    task automatic test_flush_resync();
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) set_slot(k, 32'h4000 + 32'(16 * p + 4 * k), $urandom);
            trace_rv_i_valid_ip = 3'b111;
            tick();
        end
        set_idle();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        n_vec++;
        if ({overflow, out_valid, out_addr} !== {1'b1, 1'b1, 32'h4008}) begin
            $display("FAIL flush_pre got ovf=%b v=%b a=%h exp 1 1 4008", overflow, out_valid, out_addr);
            n_bad++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({out_valid, overflow} !== 2'b00) begin $display("FAIL flush_post got v=%b ovf=%b exp 0 0", out_valid, overflow); n_bad++; end
        set_slot(0, 32'h4100, 32'h1);
        trace_rv_i_valid_ip = 3'b001;
        tick();
        set_idle();
        n_vec++;
        if ({out_valid, out_addr} !== {1'b1, 32'h4100}) begin
            $display("FAIL flush_run got v=%b a=%h exp 1 4100", out_valid, out_addr);
            n_bad++;
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) set_slot(k, 32'h5000 + 32'(4 * k), $urandom);
        trace_rv_i_valid_ip = 3'b111;
        tick();
        set_idle();
        #2;
        rst_l = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({out_valid, overflow, dut_fields} !== 106'd0) begin
            $display("FAIL rstmid_async got v=%b ovf=%b f=%h exp 0", out_valid, overflow, dut_fields);
            n_bad++;
        end
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (out_valid !== 1'b0) begin $display("FAIL rstmid_stale%0d got %b exp 0", c, out_valid); n_bad++; end
            tick();
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        trace_rv_i_valid_ip = 3'b111;
        repeat (21900) tick();
        set_idle();
        out_ready = 1'b1;
        repeat (6) tick();
        n_vec++;
        if ({out_valid, out_marker, out_tval} !== {1'b1, 1'b1, 32'h0000_FFFF}) begin
            $display("FAIL sat_marker got v=%b m=%b t=%h exp 1 1 0000ffff", out_valid, out_marker, out_tval);
            n_bad++;
        end
        tick();
    endtask

    task automatic test_random();
        trec_t e;
        for (int c = 0; c < 4000; c++) begin
            enable = ($urandom_range(0, 99) < 93);
            trace_rv_i_valid_ip     = enable ? 3'($urandom_range(0, 7)) : 3'b000;
            trace_rv_i_address_ip   = {$urandom, $urandom, $urandom};
            trace_rv_i_insn_ip      = {$urandom, $urandom, $urandom};
            trace_rv_i_exception_ip = 3'($urandom & $urandom & $urandom);
            trace_rv_i_interrupt_ip = 3'($urandom & $urandom & $urandom);
            trace_rv_i_ecause_ip    = 5'($urandom);
            trace_rv_i_tval_ip      = $urandom;
            out_ready               = ($urandom_range(0, 99) < 45);
            flush                   = ($urandom_range(0, 99) < 2);
            tick();
            e = exp_head();
            n_vec++;
            if (out_valid !== ((q.size() > 0) || (m_mode == 2))) begin
                $display("FAIL rand_valid c=%0d got %b exp %b", c, out_valid, (q.size() > 0) || (m_mode == 2));
                n_bad++;
            end
            n_vec++;
            if (overflow !== (m_mode == 2)) begin
                $display("FAIL rand_overflow c=%0d got %b exp %b", c, overflow, m_mode == 2);
                n_bad++;
            end
            n_vec++;
            if (dut_fields !== pack(e)) begin
                $display("FAIL rand_fields c=%0d got %h exp %h", c, dut_fields, pack(e));
                n_bad++;
            end
        end
        set_idle();
        enable = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_l = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        trace_rv_i_address_ip = '0;
        trace_rv_i_insn_ip = '0;
        set_idle();
        model_reset();
        #1 rst_l = 1'b0;
        #1;
        test_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_l = 1'b1;
        test_basic();
        test_gap();
        test_overflow();
        test_stall();
        test_flush_resync();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
